sdram_read: RTL and testbench
=============================

SDRAM_READ -- requirements
Module: sdram_read

Interface
REQ-001 Parameter CAS_LAT, default 3: SDRAM CAS latency in clocks; legal values 2 and 3.
REQ-002 Parameter T_RCD, default 2: NOP cycles between ACT and the first READ.
REQ-003 Parameter T_RP, default 2: NOP cycles after PRE before the next state.
REQ-004 Parameter END_ROW, default 1: last row address read in a transfer; rows 0..END_ROW are read.
REQ-005 sys_clk  in  1  single clock; all logic on the rising edge.
REQ-006 sys_rst  in  1  asynchronous, active-high reset.
REQ-007 read_trig  in  1  one-cycle pulse that starts a transfer.
REQ-008 read_en  in  1  arbiter grant; sampled only in REQ.
REQ-009 refresh_req  in  1  refresh pending from the refresh block.
REQ-010 sdram_dq  in  16  SDRAM data bus input.
REQ-011 read_req  out  1  request to the arbiter; high exactly while the FSM is in REQ.
REQ-012 read_end  out  1  one-cycle pulse when the whole transfer is complete.
REQ-013 burst_end  out  1  one-cycle pulse when the FSM leaves RD to serve a refresh.
REQ-014 read_cmd  out  4  registered {CS_n,RAS_n,CAS_n,WE_n}.
REQ-015 read_addr  out  12  registered SDRAM address.
REQ-016 bank_addr  out  2  constant 2'b00.
REQ-017 rd_data  out  16  captured read data.
REQ-018 rd_data_valid  out  1  rd_data qualifier.

Function
REQ-019 Command encodings SHALL be: NOP 0111, ACT 0011, READ 0101, PRE 0010.
REQ-020 The FSM SHALL be one-hot with five states: IDLE, REQ, ACT, RD, PRE.
REQ-021 IDLE->REQ SHALL occur on read_trig; read_trig SHALL be ignored in any other state.
REQ-022 REQ->ACT SHALL occur on read_en=1; otherwise the FSM SHALL hold in REQ.
REQ-023 ACT SHALL issue ACT with read_addr=row on its first cycle, then T_RCD NOPs, then go to RD.
REQ-024 RD SHALL be paced by a 2-bit burst_cnt.
REQ-025 In RD, a READ with read_addr={3'b000,col[8:0]} SHALL be issued when burst_cnt=0; NOP otherwise (burst length 4).
REQ-026 col SHALL advance by 4 when burst_cnt=3.
REQ-027 RD exit SHALL be evaluated only at burst_cnt=3; a burst SHALL never be truncated.
REQ-028 RD exit priority SHALL be:
- (a) last burst of row END_ROW (col=508): ->PRE, then IDLE;
- (b) refresh_req: ->PRE, pulse burst_end, then REQ;
- (c) col=508 on any other row: ->PRE, then ACT.
REQ-029 When col=508 completes, col SHALL wrap to 0 and row SHALL increment.
REQ-030 If refresh_req coincides with a row end, REQ-029 SHALL apply and PRE SHALL exit to REQ.
REQ-031 PRE SHALL issue PRE with read_addr=12'h400 (A10, all banks) on its first cycle, then T_RP NOPs, then take the recorded exit.
REQ-032 read_end SHALL pulse on the PRE->IDLE cycle; row and col SHALL clear to 0 at the same time.
REQ-033 A refresh resume SHALL re-ACT the same row and continue at the saved col; no data SHALL be skipped or repeated.
REQ-034 A READ issued on cycle N SHALL yield sdram_dq sampled at N+CAS_LAT..N+CAS_LAT+3.
REQ-035 rd_data SHALL be registered with rd_data_valid=1 at N+CAS_LAT+1..N+CAS_LAT+4.
REQ-036 The capture pipeline SHALL be a shift register of READ issues, independent of FSM state, so it drains after the FSM leaves RD.
REQ-037 read_addr SHALL be 0 when no ACT, READ or PRE is issued.

Reset
REQ-038 On sys_rst=1, asynchronously: state=IDLE; read_cmd=0111; read_addr=0; rd_data=0; all pulses, flags and counters 0; pipeline cleared.
REQ-039 Reset mid-transfer SHALL abandon the transfer with no read_end; the next read_trig SHALL restart at row 0, col 0.

Verification
REQ-040 Basic transfer: read_trig, read_en held high, sdram_dq model returning col index, END_ROW=1 -> read_cmd sequence ACT, 2 NOP, READ every 4 cycles, 128 READs per row, PRE with addr 400h; 1024 valid words in order; single read_end.
REQ-041 Latency: READ at cycle N, CAS_LAT=3 -> rd_data_valid high N+4..N+7; repeat with CAS_LAT=2 -> N+3..N+6.
REQ-042 Refresh: refresh_req asserted at burst_cnt=1 of col 40 -> burst completes, burst_end pulses, PRE, REQ; then read_en -> ACT same row, next READ col 44.
REQ-043 Grant stall: read_en held low 10 cycles in REQ -> read_req=1 and read_cmd=NOP throughout; no ACT issued.
REQ-044 Row crossing with simultaneous refresh_req at col 508, row 0 -> PRE->REQ; on resume, ACT row 1 and READ col 0.
REQ-045 Async reset in the middle of RD -> outputs return to reset values within the same cycle; read_trig ignored while busy; after reset, read_trig starts at row 0.

Source files
------------

// File: rtl/sdram_read.sv
// SDRAM page-read engine: requests the bus, opens rows 0..END_ROW, streams
// 4-word bursts across every column, yields to refresh between bursts and captures data.
`timescale 1ns/1ps

module sdram_read #(
  parameter int CAS_LAT = 3,
  parameter int T_RCD   = 2,
  parameter int T_RP    = 2,
  parameter int END_ROW = 1
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        read_trig,
  input  logic        read_en,
  input  logic        refresh_req,
  input  logic [15:0] sdram_dq,
  output logic        read_req,
  output logic        read_end,
  output logic        burst_end,
  output logic [3:0]  read_cmd,
  output logic [11:0] read_addr,
  output logic [1:0]  bank_addr,
  output logic [15:0] rd_data,
  output logic        rd_data_valid
);

  localparam logic [3:0]  CMD_NOP   = 4'b0111;
  localparam logic [3:0]  CMD_ACT   = 4'b0011;
  localparam logic [3:0]  CMD_READ  = 4'b0101;
  localparam logic [3:0]  CMD_PRE   = 4'b0010;
  localparam logic [11:0] ADDR_ALL  = 12'h400;
  localparam logic [8:0]  LAST_COL  = 9'd508;
  localparam logic [11:0] LAST_ROW  = 12'(END_ROW);
  localparam logic [3:0]  RCD_LAST  = 4'(T_RCD);
  localparam logic [3:0]  RP_LAST   = 4'(T_RP);
  localparam int          PIPE_W    = CAS_LAT + 3;

  typedef enum logic [4:0] {
    ST_IDLE = 5'b00001,
    ST_REQ  = 5'b00010,
    ST_ACT  = 5'b00100,
    ST_RD   = 5'b01000,
    ST_PRE  = 5'b10000
  } state_t;

  typedef enum logic [1:0] {
    EXIT_IDLE = 2'd0,
    EXIT_REQ  = 2'd1,
    EXIT_ACT  = 2'd2
  } exit_t;

  state_t             state_r;
  exit_t              exit_r;
  logic [3:0]         wait_cnt_r;
  logic [1:0]         burst_cnt_r;
  logic [8:0]         col_r;
  logic [11:0]        row_r;
  logic [PIPE_W-1:0]  rd_pipe_r;

  logic               row_done_s;
  logic [8:0]         col_next_s;
  logic [11:0]        row_next_s;
  logic               capture_s;

  assign bank_addr  = 2'b00;
  assign row_done_s = (col_r == LAST_COL);
  // The 9-bit column wraps 508+4 back to 0, which is exactly the row-change point.
  assign col_next_s = col_r + 9'd4;
  assign row_next_s = row_done_s ? (row_r + 12'd1) : row_r;

  // Main sequencer: state, address counters and all registered command outputs.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_r     <= ST_IDLE;
      exit_r      <= EXIT_IDLE;
      wait_cnt_r  <= 4'd0;
      burst_cnt_r <= 2'd0;
      col_r       <= 9'd0;
      row_r       <= 12'd0;
      read_req    <= 1'b0;
      read_end    <= 1'b0;
      burst_end   <= 1'b0;
      read_cmd    <= CMD_NOP;
      read_addr   <= 12'd0;
    end else begin
      read_req  <= 1'b0;
      read_end  <= 1'b0;
      burst_end <= 1'b0;
      read_cmd  <= CMD_NOP;
      read_addr <= 12'd0;
      case (state_r)
        ST_IDLE: begin
          if (read_trig) begin
            state_r  <= ST_REQ;
            read_req <= 1'b1;
          end
        end
        ST_REQ: begin
          if (read_en) begin
            state_r    <= ST_ACT;
            wait_cnt_r <= 4'd0;
            read_cmd   <= CMD_ACT;
            read_addr  <= row_r;
          end else begin
            read_req <= 1'b1;
          end
        end
        ST_ACT: begin
          if (wait_cnt_r == RCD_LAST) begin
            state_r     <= ST_RD;
            burst_cnt_r <= 2'd0;
            read_cmd    <= CMD_READ;
            read_addr   <= {3'b000, col_r};
          end else begin
            wait_cnt_r <= wait_cnt_r + 4'd1;
          end
        end
        ST_RD: begin
          burst_cnt_r <= burst_cnt_r + 2'd1;
          if (burst_cnt_r == 2'd3) begin
            col_r <= col_next_s;
            row_r <= row_next_s;
            // Last-row end outranks refresh; a refresh at any other row end still advances the row.
            if (row_done_s && (row_r == LAST_ROW)) begin
              state_r    <= ST_PRE;
              exit_r     <= EXIT_IDLE;
              wait_cnt_r <= 4'd0;
              read_cmd   <= CMD_PRE;
              read_addr  <= ADDR_ALL;
            end else if (refresh_req) begin
              state_r    <= ST_PRE;
              exit_r     <= EXIT_REQ;
              wait_cnt_r <= 4'd0;
              burst_end  <= 1'b1;
              read_cmd   <= CMD_PRE;
              read_addr  <= ADDR_ALL;
            end else if (row_done_s) begin
              state_r    <= ST_PRE;
              exit_r     <= EXIT_ACT;
              wait_cnt_r <= 4'd0;
              read_cmd   <= CMD_PRE;
              read_addr  <= ADDR_ALL;
            end else begin
              read_cmd  <= CMD_READ;
              read_addr <= {3'b000, col_next_s};
            end
          end
        end
        ST_PRE: begin
          if (wait_cnt_r == RP_LAST) begin
            case (exit_r)
              EXIT_REQ: begin
                state_r  <= ST_REQ;
                read_req <= 1'b1;
              end
              EXIT_ACT: begin
                state_r    <= ST_ACT;
                wait_cnt_r <= 4'd0;
                read_cmd   <= CMD_ACT;
                read_addr  <= row_r;
              end
              default: begin
                state_r  <= ST_IDLE;
                read_end <= 1'b1;
                row_r    <= 12'd0;
                col_r    <= 9'd0;
              end
            endcase
          end else begin
            wait_cnt_r <= wait_cnt_r + 4'd1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // A READ seen on the command bus opens a 4-word capture window CAS_LAT cycles later.
  assign capture_s = |rd_pipe_r[PIPE_W-1:CAS_LAT-1];

  // Read-data capture, driven only by issued READs so it drains after the FSM moves on.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      rd_pipe_r     <= '0;
      rd_data       <= 16'd0;
      rd_data_valid <= 1'b0;
    end else begin
      rd_pipe_r     <= {rd_pipe_r[PIPE_W-2:0], (read_cmd == CMD_READ)};
      rd_data_valid <= capture_s;
      if (capture_s) begin
        rd_data <= sdram_dq;
      end else begin
        rd_data <= rd_data;
      end
    end
  end

endmodule

// File: tb/tb_sdram_read.sv
// Randomized bench for sdram_read: two instances (CAS latency 3 and 2) share stimulus and
// are compared every cycle against a burst-level command schedule and a word-stream data model.
`timescale 1ns/1ps

module tb_sdram_read;

  localparam int T_RCD   = 2;
  localparam int T_RP    = 2;
  localparam int END_ROW = 1;
  localparam int CL_A    = 3;
  localparam int CL_B    = 2;
  localparam int WORDS   = (END_ROW + 1) * 512;

  localparam logic [3:0] C_NOP  = 4'b0111;
  localparam logic [3:0] C_ACT  = 4'b0011;
  localparam logic [3:0] C_READ = 4'b0101;
  localparam logic [3:0] C_PRE  = 4'b0010;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        read_trig = 1'b0;
  logic        read_en = 1'b0;
  logic        refresh_req = 1'b0;
  logic [15:0] a_dq = 16'd0;
  logic [15:0] b_dq = 16'd0;

  logic        a_req, a_end, a_bend, a_valid;
  logic [3:0]  a_cmd;
  logic [11:0] a_addr;
  logic [1:0]  a_bank;
  logic [15:0] a_data;
  logic        b_req, b_end, b_bend, b_valid;
  logic [3:0]  b_cmd;
  logic [11:0] b_addr;
  logic [1:0]  b_bank;
  logic [15:0] b_data;

  sdram_read #(.CAS_LAT(CL_A), .T_RCD(T_RCD), .T_RP(T_RP), .END_ROW(END_ROW)) u_cl3 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .read_trig(read_trig), .read_en(read_en),
    .refresh_req(refresh_req), .sdram_dq(a_dq), .read_req(a_req), .read_end(a_end),
    .burst_end(a_bend), .read_cmd(a_cmd), .read_addr(a_addr), .bank_addr(a_bank),
    .rd_data(a_data), .rd_data_valid(a_valid)
  );

  sdram_read #(.CAS_LAT(CL_B), .T_RCD(T_RCD), .T_RP(T_RP), .END_ROW(END_ROW)) u_cl2 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .read_trig(read_trig), .read_en(read_en),
    .refresh_req(refresh_req), .sdram_dq(b_dq), .read_req(b_req), .read_end(b_end),
    .burst_end(b_bend), .read_cmd(b_cmd), .read_addr(b_addr), .bank_addr(b_bank),
    .rd_data(b_data), .rd_data_valid(b_valid)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // ---------------- reference model: expected command schedule ----------------
  typedef struct {
    logic [3:0]  cmd;
    logic [11:0] addr;
    bit          bend;
  } exp_t;
  typedef struct {
    int cyc;
    int base;
  } rdrec_t;

  exp_t   q[$];
  rdrec_t recs[$];
  int m_mode;   // 0 idle, 1 waiting for grant, 2 transferring
  int m_next;   // on queue drain: 0 burst-end decision, 1 start burst, 2 precharge exit
  int m_exit;   // 0 idle, 1 back to request, 2 open next row
  int m_row, m_col;
  logic [3:0]  e_cmd;
  logic [11:0] e_addr;
  bit e_req, e_end, e_bend;

  task automatic push_act();
    q.push_back('{cmd: C_ACT, addr: 12'(m_row), bend: 1'b0});
    for (int i = 0; i < T_RCD; i++) q.push_back('{cmd: C_NOP, addr: 12'd0, bend: 1'b0});
    m_next = 1;
  endtask

  task automatic push_burst();
    q.push_back('{cmd: C_READ, addr: 12'(m_col), bend: 1'b0});
    for (int i = 0; i < 3; i++) q.push_back('{cmd: C_NOP, addr: 12'd0, bend: 1'b0});
    m_next = 0;
  endtask

  task automatic push_pre(input bit b);
    q.push_back('{cmd: C_PRE, addr: 12'h400, bend: b});
    for (int i = 0; i < T_RP; i++) q.push_back('{cmd: C_NOP, addr: 12'd0, bend: 1'b0});
    m_next = 2;
  endtask

  task automatic advance();
    m_col += 4;
    if (m_col == 512) begin
      m_col = 0;
      m_row++;
    end
  endtask

  task automatic model_reset();
    q.delete();
    recs.delete();
    m_mode = 0; m_next = 0; m_exit = 0; m_row = 0; m_col = 0;
    e_cmd = C_NOP; e_addr = 12'd0; e_req = 0; e_end = 0; e_bend = 0;
  endtask

  // Expected outputs for the current cycle, from the inputs sampled at the last edge.
  task automatic model_step();
    exp_t e;
    e_req = 0; e_end = 0; e_bend = 0; e_cmd = C_NOP; e_addr = 12'd0;
    if (m_mode == 2 && q.size() == 0) begin
      if (m_next == 1) begin
        push_burst();
      end else if (m_next == 0) begin
        if (m_col == 508 && m_row == END_ROW) begin
          advance(); m_exit = 0; push_pre(1'b0);
        end else if (refresh_req) begin
          advance(); m_exit = 1; push_pre(1'b1);
        end else if (m_col == 508) begin
          advance(); m_exit = 2; push_pre(1'b0);
        end else begin
          advance(); push_burst();
        end
      end else begin
        if (m_exit == 0) begin
          m_mode = 0; e_end = 1; m_row = 0; m_col = 0;
        end else if (m_exit == 1) begin
          m_mode = 1; e_req = 1;
        end else begin
          push_act();
        end
      end
    end else if (m_mode == 0) begin
      if (read_trig) begin
        m_mode = 1; e_req = 1;
      end
    end else if (m_mode == 1) begin
      if (read_en) begin
        m_mode = 2; push_act();
      end else begin
        e_req = 1;
      end
    end
    if (q.size() > 0) begin
      e = q.pop_front();
      e_cmd = e.cmd; e_addr = e.addr; e_bend = e.bend;
      if (e.cmd == C_READ) recs.push_back('{cyc: cyc, base: m_row * 512 + int'(e.addr)});
    end
    while (recs.size() > 0 && recs[0].cyc < cyc - 12) void'(recs.pop_front());
  endtask

  task automatic exp_rd(input int cl, output bit v, output logic [15:0] w);
    v = 0; w = 16'd0;
    foreach (recs[i]) begin
      int d;
      d = cyc - recs[i].cyc;
      if (d >= cl + 1 && d <= cl + 4) begin
        v = 1; w = 16'(recs[i].base + d - cl - 1);
      end
    end
  endtask

  task automatic dq_for(input int cl, output logic [15:0] v);
    v = 16'($urandom);
    foreach (recs[i]) begin
      int d;
      d = cyc - recs[i].cyc;
      if (d >= cl && d <= cl + 3) v = 16'(recs[i].base + d - cl);
    end
  endtask

  task automatic cmp_dut(input string p, input int cl, input logic [3:0] cmd,
                         input logic [11:0] addr, input logic req, input logic rend,
                         input logic bend, input logic [1:0] bank, input logic [15:0] data,
                         input logic valid);
    bit v;
    logic [15:0] w;
    exp_rd(cl, v, w);
    check_eq({p, "_cmd"}, cmd, e_cmd);
    check_eq({p, "_addr"}, addr, e_addr);
    check_eq({p, "_read_req"}, req, e_req);
    check_eq({p, "_read_end"}, rend, e_end);
    check_eq({p, "_burst_end"}, bend, e_bend);
    check_eq({p, "_bank"}, bank, 2'b00);
    check_eq({p, "_valid"}, valid, v);
    if (v) check_eq({p, "_data"}, data, w);
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_cl3_cmd"}, a_cmd, C_NOP);
    check_eq({tag, "_cl3_addr"}, a_addr, 12'd0);
    check_eq({tag, "_cl3_req"}, a_req, 1'b0);
    check_eq({tag, "_cl3_valid"}, a_valid, 1'b0);
    check_eq({tag, "_cl3_data"}, a_data, 16'd0);
    check_eq({tag, "_cl3_pulses"}, {a_end, a_bend}, 2'b00);
    check_eq({tag, "_cl2_cmd"}, b_cmd, C_NOP);
    check_eq({tag, "_cl2_addr"}, b_addr, 12'd0);
    check_eq({tag, "_cl2_valid"}, b_valid, 1'b0);
    check_eq({tag, "_cl2_data"}, b_data, 16'd0);
  endtask

  // ---------------- stimulus ----------------
  bit start_pending = 0, trig_noise = 0, en_noise = 0, en_rand = 0, arm_fire = 0, xfer_done = 0;
  int en_delay = 0, req_wait = 0, rfr_rate = 0;
  int a_words = 0, b_words = 0, a_ends = 0;
  int t_row[$], t_col[$];

  task automatic drive();
    if (start_pending && m_mode == 0) begin
      read_trig = 1'b1; start_pending = 0;
    end else if (trig_noise && m_mode != 0) read_trig = 1'($urandom_range(0, 1));
    else read_trig = 1'b0;

    if (m_mode == 1) begin
      if (req_wait == 0 && en_rand) en_delay = $urandom_range(0, 6);
      read_en = (req_wait >= en_delay);
      req_wait++;
    end else begin
      req_wait = 0;
      read_en = en_noise ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    if (e_bend || e_end) refresh_req = 1'b0;
    else if (arm_fire) refresh_req = 1'b1;
    else if (rfr_rate > 0 && m_mode == 2 && $urandom_range(0, rfr_rate - 1) == 0) refresh_req = 1'b1;
    arm_fire = 0;
    if (t_row.size() > 0 && e_cmd == C_READ && int'(e_addr) == t_col[0] && m_row == t_row[0]) begin
      arm_fire = 1;
      void'(t_row.pop_front());
      void'(t_col.pop_front());
    end

    dq_for(CL_A, a_dq);
    dq_for(CL_B, b_dq);
  endtask

  task automatic step();
    @(negedge sys_clk);
    cyc++;
    model_step();
    cmp_dut("cl3", CL_A, a_cmd, a_addr, a_req, a_end, a_bend, a_bank, a_data, a_valid);
    cmp_dut("cl2", CL_B, b_cmd, b_addr, b_req, b_end, b_bend, b_bank, b_data, b_valid);
    if (a_valid) a_words++;
    if (b_valid) b_words++;
    if (a_end) a_ends++;
    if (e_end) xfer_done = 1;
    drive();
  endtask

  task automatic run_transfer(input string name);
    a_words = 0; b_words = 0; a_ends = 0; xfer_done = 0; start_pending = 1;
    for (int i = 0; i < 6000 && !xfer_done; i++) step();
    check_eq({name, "_done"}, xfer_done, 1'b1);
    repeat (8) step();
    check_eq({name, "_cl3_words"}, a_words, WORDS);
    check_eq({name, "_cl2_words"}, b_words, WORDS);
    check_eq({name, "_read_end_count"}, a_ends, 1);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge sys_clk);
    check_reset("reset");
    sys_rst = 1'b0;

    // basic transfer: grant held high, no refresh
    run_transfer("basic");

    // grant stall, refresh mid-row at col 40, refresh coinciding with the row-0 end
    en_delay = 10;
    t_row.push_back(0); t_col.push_back(40);
    t_row.push_back(0); t_col.push_back(508);
    run_transfer("refresh");
    check_eq("refresh_targets_hit", t_row.size(), 0);

    // randomized grants, refreshes and spurious triggers/grants while busy
    en_rand = 1; en_noise = 1; trig_noise = 1; rfr_rate = 150;
    run_transfer("rand1");
    run_transfer("rand2");

    // asynchronous reset while reading, then a fresh transfer from row 0
    a_ends = 0; xfer_done = 0; start_pending = 1;
    repeat ($urandom_range(150, 700)) step();
    for (int i = 0; i < 8 && e_cmd != C_READ; i++) step();
    #2 sys_rst = 1'b1;
    #1 check_reset("midrst");
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    read_trig = 1'b0;
    refresh_req = 1'b0;
    arm_fire = 0;
    start_pending = 0;
    model_reset();
    check_eq("midrst_no_read_end", a_ends, 0);
    run_transfer("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
